// File: rtl/operand_fetch_stage_pkg.sv
// Shared constants and types for the operand fetch stage and its register file.
package operand_fetch_stage_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned REG_ADDR_W = 3;
  localparam int unsigned NUM_REGS   = 8;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     data_t;

  localparam reg_addr_t ZERO_REG = '0;

  // R0 is hardwired to zero, so it is never a write or scoreboard target.
  function automatic logic isWritable(input reg_addr_t addr);
    return addr != ZERO_REG;
  endfunction

endpackage

// File: rtl/operand_fetch_stage_reg_file_2r1w.sv
// Register storage: two combinational read ports with write-back bypass, one write port.
module reg_file_2r1w
  import operand_fetch_stage_pkg::*;
#(
  parameter int unsigned NUM_REGS = operand_fetch_stage_pkg::NUM_REGS,
  parameter int unsigned DATA_W   = operand_fetch_stage_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wbEn,
  input  reg_addr_t         wbAddr,
  input  logic [DATA_W-1:0] wbData,
  input  reg_addr_t         rs1Addr,
  input  reg_addr_t         rs2Addr,
  output logic [DATA_W-1:0] rdData1,
  output logic [DATA_W-1:0] rdData2
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wbActive;

  assign wbActive = wbEn && isWritable(wbAddr);

  // Storage array: cleared on reset, written on write-back except for R0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wbActive) begin
      regs[wbAddr] <= wbData;
    end
  end

  // Read port 1: same-cycle write-back data takes priority over stored value.
  always_comb begin
    rdData1 = regs[rs1Addr];
    if (!isWritable(rs1Addr)) begin
      rdData1 = '0;
    end else if (wbActive && (wbAddr == rs1Addr)) begin
      rdData1 = wbData;
    end
  end

  // Read port 2: same bypass rule as port 1.
  always_comb begin
    rdData2 = regs[rs2Addr];
    if (!isWritable(rs2Addr)) begin
      rdData2 = '0;
    end else if (wbActive && (wbAddr == rs2Addr)) begin
      rdData2 = wbData;
    end
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: register read, busy scoreboard and registered valid/ready output.
module operand_fetch_stage
  import operand_fetch_stage_pkg::*;
#(
  parameter int unsigned NUM_REGS = operand_fetch_stage_pkg::NUM_REGS,
  parameter int unsigned DATA_W   = operand_fetch_stage_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instValid,
  output logic              instReady,
  input  reg_addr_t         rs1Addr,
  input  reg_addr_t         rs2Addr,
  input  reg_addr_t         rdAddrIn,
  input  logic              wbEn,
  input  reg_addr_t         wbAddr,
  input  logic [DATA_W-1:0] wbData,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  output reg_addr_t         rdAddrOut,
  output logic              opValid,
  input  logic              opReady
);

  logic [NUM_REGS-1:0] busy;
  logic [DATA_W-1:0]   fetch1;
  logic [DATA_W-1:0]   fetch2;
  logic                rs1Hazard;
  logic                rs2Hazard;
  logic                accept;

  reg_file_2r1w #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W)
  ) uRegFile (
    .clk     (clk),
    .rst_n   (rst_n),
    .wbEn    (wbEn),
    .wbAddr  (wbAddr),
    .wbData  (wbData),
    .rs1Addr (rs1Addr),
    .rs2Addr (rs2Addr),
    .rdData1 (fetch1),
    .rdData2 (fetch2)
  );

  // Hazard detection: a busy source is fine only if its write-back lands this cycle.
  always_comb begin
    rs1Hazard = busy[rs1Addr] && isWritable(rs1Addr) && !(wbEn && (wbAddr == rs1Addr));
    rs2Hazard = busy[rs2Addr] && isWritable(rs2Addr) && !(wbEn && (wbAddr == rs2Addr));
    instReady = !(rs1Hazard || rs2Hazard) && (!opValid || opReady);
    accept    = instValid && instReady;
  end

  // Busy scoreboard: set by the later assignment so issue wins over a same-edge clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      if (wbEn && isWritable(wbAddr)) begin
        busy[wbAddr] <= 1'b0;
      end
      if (accept && isWritable(rdAddrIn)) begin
        busy[rdAddrIn] <= 1'b1;
      end
    end
  end

  // Output register: load on accept, drop valid on drain, hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      readData1 <= '0;
      readData2 <= '0;
      rdAddrOut <= ZERO_REG;
      opValid   <= 1'b0;
    end else if (accept) begin
      readData1 <= fetch1;
      readData2 <= fetch2;
      rdAddrOut <= rdAddrIn;
      opValid   <= 1'b1;
    end else if (opValid && opReady) begin
      opValid   <= 1'b0;
    end
  end

endmodule
